fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage of the 5-stage RISC-V pipeline: owns the PC, issues requests on the
//  instruction-memory req/ready/rvalid interface and drives pc_f/instruction_f into the IF/ID
//  register. Handles hazard stalls and execute-stage redirects (taken branch/jump), including
//  discarding responses to stale requests. One outstanding memory request at a time.
// PARAMETERS
//  WIDTH     32     PC / address / instruction width
//  RESET_PC  32'h0  PC loaded on reset (first fetch address)
// PORTS
//  clk            in   1      clock, all state on posedge
//  reset          in   1      asynchronous, active-high reset
//  stall_f        in   1      hazard unit: hold current fetch output
//  redirect_e     in   1      execute: taken branch/jump, load redirect_pc
//  redirect_pc    in   WIDTH  redirect target
//  imem_req       out  1      request valid
//  imem_addr      out  WIDTH  request address (= pc register)
//  imem_ready     in   1      request accepted this cycle (req & ready = handshake)
//  imem_rvalid    in   1      response data valid (>=1 cycle after acceptance)
//  imem_rdata     in   WIDTH  response instruction
//  pc_f           out  WIDTH  PC of presented instruction
//  instruction_f  out  WIDTH  presented instruction; 32'h0 when valid_f=0
//  valid_f        out  1      instruction_f valid; control drives IF/ID flush when 0
//  misalign_f     out  1      presented PC misaligned (see CONFIGURATION)
// BEHAVIOUR
//  - State: pc_q, instr_q, FSM {REQ, WAIT, HOLD, DROP}. All outputs decoded from registers.
//  - Reset (async): state=REQ, pc_q=RESET_PC, instr_q=0; imem_req=0 during reset, then 1
//    from first cycle after deassertion; pc_f=imem_addr=RESET_PC, instruction_f=0, valid_f=0,
//    misalign_f=0.
//  - REQ: imem_req=1, imem_addr=pc_q (stable until accepted). req&ready -> WAIT.
//  - WAIT: imem_req=0. imem_rvalid -> instr_q<=imem_rdata, -> HOLD.
//  - HOLD: valid_f=1, pc_f=pc_q, instruction_f=instr_q. !stall_f -> pc_q<=pc_q+4 (mod 2^WIDTH,
//    wraps), -> REQ (IF/ID samples this same edge). stall_f -> stay, outputs unchanged.
//  - DROP: stale request outstanding; imem_req=0. imem_rvalid -> data discarded, -> REQ.
//  - Redirect (priority over stall and all handshakes), in every state: pc_q<=redirect_pc,
//    valid_f=0 next cycle. Next state: REQ from REQ w/o acceptance and from HOLD; DROP from
//    REQ with same-cycle acceptance and from WAIT without rvalid; REQ from WAIT/DROP with
//    same-cycle rvalid (response discarded); DROP stays DROP.
//  - Outside HOLD: valid_f=0, instruction_f=0, pc_f=pc_q.
//  - imem_rvalid in REQ or HOLD is ignored. stall_f ignored outside HOLD.
//  - Best throughput 1 instr / 3 cycles (REQ, WAIT w/ rvalid, HOLD) with 1-cycle memory.
//  - Reset mid-transaction: FSM returns to REQ; a pending response after reset is ignored
//    (arrives in REQ).
// CONFIGURATION
//  FETCH_MISALIGN_EN defined: in REQ, if pc_q[1:0]!=0 no request is issued (imem_req=0);
//    -> HOLD with instr_q=0, valid_f=1, misalign_f=1. Stays in HOLD (ignores stall_f, no PC
//    increment) until redirect_e.
//  Not defined: redirect_pc[1:0] forced to 2'b00 when loaded; misalign_f tied 0.
// TESTING
//  1 Reset, ready=1, rvalid 1 cycle after accept, rdata=0x00500093 -> req addr 0x0; HOLD
//    shows pc_f=0x0, instr=0x00500093, valid_f=1; next req addr 0x4.
//  2 stall_f=1 for 3 cycles in HOLD at pc 0x8 -> pc_f/instruction_f/valid_f frozen,
//    imem_req=0; release -> next req addr 0xC.
//  3 Redirect to 0x100 in WAIT, rvalid 2 cycles later with 0xDEADBEEF -> DROP, data never
//    shown (valid_f=0); next req addr 0x100.
//  4 Redirect to 0x40 with stall_f=1 in HOLD -> valid_f=0 next cycle, req addr 0x40.
//  5 imem_ready=0 for 4 cycles -> imem_addr stable at pc_q, imem_req held 1; ready then
//    accepts once only.
//  6 FETCH_MISALIGN_EN, redirect to 0x102 -> no req, valid_f=1, misalign_f=1, instr=0;
//    redirect to 0x200 clears it, req addr 0x200. Macro off: same redirect -> req addr 0x100.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs a single-outstanding imem request, and presents
// pc_f/instruction_f to IF/ID. Optional macro FETCH_MISALIGN_EN flags misaligned PCs instead of masking them.
module fetch_unit #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_f,
    input  logic             redirect_e,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ready,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] pc_f,
    output logic [WIDTH-1:0] instruction_f,
    output logic             valid_f,
    output logic             misalign_f
);

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_DROP = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] redirect_tgt;
    logic             pc_misaligned;
    logic             accept;

`ifdef FETCH_MISALIGN_EN
    assign pc_misaligned = |pc_q[1:0];
    assign redirect_tgt  = redirect_pc;
`else
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign pc_misaligned        = 1'b0;
    assign redirect_tgt         = {redirect_pc[WIDTH-1:2], 2'b00};
`endif

    // The request is masked while reset is held so memory never sees a fetch from a resetting core.
    assign imem_req  = (state_q == ST_REQ) && !pc_misaligned && !reset;
    assign accept    = imem_req && imem_ready;
    assign imem_addr = pc_q;

    assign valid_f       = (state_q == ST_HOLD);
    assign pc_f          = pc_q;
    assign instruction_f = valid_f ? instr_q : '0;
    assign misalign_f    = valid_f && pc_misaligned;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;

        case (state_q)
            ST_REQ: begin
                if (pc_misaligned) begin
                    instr_d = '0;
                    state_d = ST_HOLD;
                end else if (accept) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!stall_f && !pc_misaligned) begin
                    pc_d    = pc_q + WIDTH'(4);
                    state_d = ST_REQ;
                end
            end
            ST_DROP: begin
                if (imem_rvalid) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase

        // A redirect overrides everything; an in-flight request becomes stale and must be drained.
        if (redirect_e) begin
            pc_d    = redirect_tgt;
            instr_d = instr_q;
            case (state_q)
                ST_REQ:           state_d = accept ? ST_DROP : ST_REQ;
                ST_WAIT, ST_DROP: state_d = imem_rvalid ? ST_REQ : ST_DROP;
                default:          state_d = ST_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a memory responder and a PC-level program-flow model feeding a scoreboard.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_f, redirect_e;
    logic [31:0] redirect_pc;
    logic        imem_req, imem_ready, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] pc_f, instruction_f;
    logic        valid_f, misalign_f;

    fetch_unit #(.WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(rst), .stall_f(stall_f), .redirect_e(redirect_e),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .pc_f(pc_f), .instruction_f(instruction_f), .valid_f(valid_f), .misalign_f(misalign_f)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Program memory contents: address 0 holds addi x1,x0,5.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return 32'h00500093 ^ (a * 32'h9E3779B1);
    endfunction

    function automatic logic [31:0] tgt_of(input logic [31:0] p);
`ifdef FETCH_MISALIGN_EN
        return p;
`else
        return {p[31:2], 2'b00};
`endif
    endfunction

    function automatic logic is_mis(input logic [31:0] p);
`ifdef FETCH_MISALIGN_EN
        return p[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    // Stimulus knobs, written by the main sequence, read by the driver.
    int          ready_pct, dly_lo, dly_hi, stall_pct, redir_pct;
    logic        force_redir;
    logic [31:0] force_pc;

    // Handshake observed by the monitor, consumed by the memory responder.
    logic        hs_seen = 1'b0;
    logic [31:0] hs_addr = '0;

    // Driver / memory responder: inputs change 1 time unit after each rising edge.
    logic        pending = 1'b0;
    logic [31:0] pend_addr;
    int          pend_cnt;
    initial begin
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        stall_f     = 1'b0;
        redirect_e  = 1'b0;
        redirect_pc = '0;
        forever begin
            @(posedge clk);
            #1;
            if (hs_seen) begin
                pending   = 1'b1;
                pend_addr = hs_addr;
                pend_cnt  = $urandom_range(dly_hi, dly_lo);
            end
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (pending) begin
                if (pend_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_fn(pend_addr);
                    pending     = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
            imem_ready = !pending && ($urandom_range(99, 0) < ready_pct);
            stall_f    = ($urandom_range(99, 0) < stall_pct);
            if (force_redir) begin
                redirect_e  = 1'b1;
                redirect_pc = force_pc;
            end else if ($urandom_range(99, 0) < redir_pct) begin
                redirect_e  = 1'b1;
                redirect_pc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                         : ($urandom & 32'h0000_0FFF);
            end else begin
                redirect_e  = 1'b0;
            end
        end
    end

    // Reference model: the architectural fetch target; the queue front is the next instruction to present.
    logic [31:0] exp_q[$];
    logic [31:0] cur;
    logic        mis, after_rst = 1'b0, redir_prev = 1'b0, prev_hs = 1'b0;
    int          nvalid = 0;
    int          idle = 0;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
            chk("rst_valid_f", {31'b0, valid_f}, 32'd0);
            chk("rst_pc_f", pc_f, 32'h0);
            chk("rst_instruction_f", instruction_f, 32'h0);
            chk("rst_misalign_f", {31'b0, misalign_f}, 32'd0);
            exp_q.delete();
            exp_q.push_back(32'h0);
            after_rst  = 1'b1;
            redir_prev = 1'b0;
            prev_hs    = 1'b0;
            hs_seen    = 1'b0;
            idle       = 0;
        end else begin
            cur = exp_q[0];
            mis = is_mis(cur);
            if (after_rst) chk("req_after_reset", {31'b0, imem_req}, {31'b0, !mis});
            after_rst = 1'b0;
            chk("pc_f", pc_f, cur);
            chk("imem_addr", imem_addr, cur);
            if (prev_hs)    chk("single_outstanding", {31'b0, imem_req}, 32'd0);
            if (redir_prev) chk("valid_after_redirect", {31'b0, valid_f}, 32'd0);
            if (mis)        chk("no_req_misaligned", {31'b0, imem_req}, 32'd0);
            if (valid_f) begin
                chk("instruction_f", instruction_f, mis ? 32'h0 : mem_fn(cur));
                chk("misalign_f", {31'b0, misalign_f}, {31'b0, mis});
                nvalid++;
                idle = 0;
            end else begin
                chk("instr_zero_when_invalid", instruction_f, 32'h0);
                chk("misalign_when_invalid", {31'b0, misalign_f}, 32'd0);
                idle++;
                if (idle >= 200) begin
                    chk("liveness_idle_cycles", idle, 0);
                    idle = 0;
                end
            end
            prev_hs    = imem_req && imem_ready;
            hs_seen    = prev_hs;
            hs_addr    = imem_addr;
            redir_prev = redirect_e;
            if (redirect_e) begin
                exp_q.delete();
                exp_q.push_back(tgt_of(redirect_pc));
            end else if (valid_f && !stall_f && !mis) begin
                void'(exp_q.pop_front());
                exp_q.push_back(cur + 32'd4);
            end
        end
    end

    task automatic do_redirect(input logic [31:0] p);
        force_pc    = p;
        force_redir = 1'b1;
        @(posedge clk);
        #2;
        force_redir = 1'b0;
    endtask

    int  n0;
    logic found;

    initial begin
        rst = 1'b1;
        ready_pct = 100; dly_lo = 0; dly_hi = 0; stall_pct = 0; redir_pct = 0;
        force_redir = 1'b0; force_pc = '0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;

        // Ideal memory: one instruction every three cycles starting at 0x0.
        repeat (10) @(posedge clk);
        n0 = nvalid;
        repeat (30) @(posedge clk);
        chk("throughput_per_30_cycles", nvalid - n0, 10);

        // Stall in HOLD for several cycles, then release.
        stall_pct = 100;
        repeat (5) @(posedge clk);
        stall_pct = 0;
        repeat (6) @(posedge clk);

        // Redirect to 0x40 while stalled in HOLD.
        stall_pct = 100;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            found = valid_f;
        end
        chk("wait_for_hold", {31'b0, found}, 32'd1);
        do_redirect(32'h40);
        stall_pct = 0;
        repeat (8) @(posedge clk);

        // Redirect to 0x100 in WAIT; the stale response arrives two cycles later.
        dly_lo = 2; dly_hi = 2;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            found = imem_req && imem_ready;
        end
        chk("wait_for_accept", {31'b0, found}, 32'd1);
        do_redirect(32'h0000_DEAC);
        do_redirect(32'h100);
        dly_lo = 0; dly_hi = 0;
        repeat (10) @(posedge clk);

        // Memory not ready for four cycles.
        ready_pct = 0;
        repeat (4) @(posedge clk);
        ready_pct = 100;
        repeat (8) @(posedge clk);

        // Misaligned redirect target, then an aligned one.
        do_redirect(32'h102);
        repeat (8) @(posedge clk);
        do_redirect(32'h200);
        repeat (8) @(posedge clk);

        // Randomized traffic with a reset in the middle.
        ready_pct = 60; dly_lo = 0; dly_hi = 4; stall_pct = 30; redir_pct = 5;
        n0 = nvalid;
        repeat (1500) @(posedge clk);
        #3 rst = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        repeat (1500) @(posedge clk);
        chk("random_progress", {31'b0, (nvalid - n0) > 100}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
